// File: rtl/control_word_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : control_word_fetch_pkg
// Purpose: Shared widths and control-word field layout for the fetch front
//          end and the ALU control-word decoder, plus the credit helper used
//          by the read-issue logic.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package control_word_fetch_pkg;

  localparam int CWF_CW_WIDTH   = 55;
  localparam int CWF_ADDR_WIDTH = 16;

  // Control word field layout, shared with the decoder.
  localparam int CW_PC_INCREMENT_BIT = 54;
  localparam int CW_ALU_OP_LSB       = 0;
  localparam int CW_ALU_OP_WIDTH     = 4;
  localparam int CW_ALU_OP_MSB       = CW_ALU_OP_LSB + CW_ALU_OP_WIDTH - 1;

  localparam int CWF_FIFO_DEPTH = 2;

  // Words that will occupy the buffer after this edge, assuming the landing
  // read is kept. A new read may only issue when this is below the depth,
  // so its data always finds a free slot.
  function automatic logic [2:0] cwf_level(input logic [1:0] occ,
                                           input logic       inflight,
                                           input logic       pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_word_fetch_if.sv
`default_nettype none
// ============================================================================
// Module : control_word_fetch_if
// Purpose: Bus bundle of the fetch unit: control-store read port and the
//          valid/ready channel toward the control-word decoder.
// Ports  : mem_read/mem_addr/mem_rdata - synchronous store, 1-cycle latency
//          cw_valid/cw_ready/control_word/cw_pc - decoder channel
//          master = fetch unit, slave = store + decoder side
// Rev    : 1.0 - initial release
// ============================================================================
interface control_word_fetch_if
  import control_word_fetch_pkg::*;
#(
  parameter int CW_WIDTH   = CWF_CW_WIDTH,
  parameter int ADDR_WIDTH = CWF_ADDR_WIDTH
) ();

  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [CW_WIDTH-1:0]   mem_rdata;
  logic                  cw_valid;
  logic                  cw_ready;
  logic [CW_WIDTH-1:0]   control_word;
  logic [ADDR_WIDTH-1:0] cw_pc;

  modport master (
    output mem_read, mem_addr, cw_valid, control_word, cw_pc,
    input  mem_rdata, cw_ready
  );

  modport slave (
    input  mem_read, mem_addr, cw_valid, control_word, cw_pc,
    output mem_rdata, cw_ready
  );

endinterface
`default_nettype wire

// File: rtl/control_word_fetch_cw_fifo2.sv
`default_nettype none
// ============================================================================
// Module : cw_fifo2
// Purpose: Two-entry synchronous FIFO with flush. Push and pop may coincide
//          at any occupancy; flush empties the buffer and wins over push.
// Ports  : clk, reset_n (async, active-low)
//          push_i/din_i  - write side
//          pop_i/dout_o  - read side, dout_o is the head entry
//          flush_i       - drop all entries
//          occ_o         - entries held (0..2)
// Rev    : 1.0 - initial release
// ============================================================================
module cw_fifo2 #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             push_i,
  input  wire logic             pop_i,
  input  wire logic             flush_i,
  input  wire logic [WIDTH-1:0] din_i,
  output logic      [WIDTH-1:0] dout_o,
  output logic      [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;

  always_comb begin
    occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      // When full, wr_ptr equals rd_ptr: a simultaneous push overwrites the
      // head that is leaving this same edge.
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign dout_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(push_i && !flush_i && occ_q == 2'd2 && !pop_i));

endmodule
`default_nettype wire

// File: rtl/control_word_fetch.sv
`default_nettype none
// ============================================================================
// Module : control_word_fetch
// Purpose: Microsequencer front end. Walks the microprogram counter, reads
//          control words from a 1-cycle-latency store and presents them to
//          the decoder over valid/ready, one word per cycle in steady state.
//          Jumps redirect the counter and drop every buffered/landing word
//          except one popped in the jump cycle itself.
// Ports  : clk, reset_n (async, active-low)
//          halt        - suppress new store reads
//          jump_valid  - redirect pulse, jump_target = new counter value
//          bus         - store port and decoder channel (master side)
// Rev    : 1.0 - initial release
// ============================================================================
module control_word_fetch
  import control_word_fetch_pkg::*;
#(
  parameter int                    CW_WIDTH   = CWF_CW_WIDTH,
  parameter int                    ADDR_WIDTH = CWF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  input  wire logic                  halt,
  input  wire logic                  jump_valid,
  input  wire logic [ADDR_WIDTH-1:0] jump_target,
  control_word_fetch_if.master       bus
);

  localparam int ENTRY_W = CW_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;
  logic                  kill_q;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            level;
  logic [1:0]            occ;
  logic [ENTRY_W-1:0]    fifo_din;
  logic [ENTRY_W-1:0]    fifo_dout;

  assign pop   = bus.cw_valid & bus.cw_ready;
  assign level = cwf_level(occ, inflight_q, pop);

  // Gated by reset_n so the strobe is low while reset is held, even though
  // the credit check alone would allow a read from an empty buffer.
  assign issue = reset_n & ~halt & ~jump_valid & (level < 3'(CWF_FIFO_DEPTH));

  // Landing data is dropped when a jump arrives or a prior jump killed it.
  assign push  = inflight_q & ~kill_q & ~jump_valid;

  always_comb begin
    pc_d = pc_q;
    if (jump_valid) begin
      pc_d = jump_target;
    end else if (issue) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      kill_q          <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_addr_q <= pc_q;
      end
      // Remembers that a jump discarded a read in the pipe; no read issues
      // in a jump cycle, so this only ever guards an empty slot.
      kill_q <= jump_valid & inflight_q;
    end
  end

  assign fifo_din = {bus.mem_rdata, inflight_addr_q};

  cw_fifo2 #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (jump_valid),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .occ_o   (occ)
  );

  assign bus.mem_read     = issue;
  assign bus.mem_addr     = pc_q;
  assign bus.cw_valid     = (occ != 2'd0);
  assign bus.control_word = fifo_dout[ENTRY_W-1:ADDR_WIDTH];
  assign bus.cw_pc        = fifo_dout[ADDR_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_control_word_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_control_word_fetch
// Purpose: Directed self-checking bench for control_word_fetch. The store
//          model returns word[i] = i, so every presented word must equal its
//          own cw_pc and follow the hand-traced address sequence.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_control_word_fetch;

  localparam int CW_W = 55;
  localparam int AW   = 16;

  logic          clk;
  logic          reset_n;
  logic          halt;
  logic          jump_valid;
  logic [AW-1:0] jump_target;

  int check_count;
  int error_count;

  control_word_fetch_if #(.CW_WIDTH(CW_W), .ADDR_WIDTH(AW)) bus ();

  control_word_fetch #(
    .CW_WIDTH   (CW_W),
    .ADDR_WIDTH (AW),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .halt        (halt),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous control store: word at address i is i.
  always @(posedge clk) begin
    if (bus.mem_read) begin
      bus.mem_rdata <= CW_W'(bus.mem_addr);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_word(input string tag, input logic [AW-1:0] addr);
    check({tag, "_valid"}, 64'(bus.cw_valid), 64'd1);
    check({tag, "_word"},  64'(bus.control_word), 64'(addr));
    check({tag, "_pc"},    64'(bus.cw_pc), 64'(addr));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 64'(bus.cw_valid), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] wrap_seq [4];
    check_count  = 0;
    error_count  = 0;
    reset_n      = 1'b0;
    halt         = 1'b0;
    jump_valid   = 1'b0;
    jump_target  = '0;
    bus.cw_ready = 1'b1;

    // Reset state
    sample();
    check("rst_valid",    64'(bus.cw_valid), 64'd0);
    check("rst_mem_read", 64'(bus.mem_read), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    check("rst_word",     64'(bus.control_word), 64'h0);
    check("rst_cw_pc",    64'(bus.cw_pc), 64'h0);

    // Startup: read from the first cycle, first word two cycles later
    next_cycle(); reset_n = 1'b1; sample();
    check("c0_mem_read", 64'(bus.mem_read), 64'd1);
    check("c0_mem_addr", 64'(bus.mem_addr), 64'h0);
    expect_idle("c0");
    next_cycle(); sample();
    check("c1_mem_addr", 64'(bus.mem_addr), 64'h1);
    expect_idle("c1");
    for (int i = 0; i < 6; i++) begin
      next_cycle(); sample();
      expect_word("stream", AW'(i));
    end

    // Back-pressure for 10 cycles: word 6 held, reads stop once full
    for (int i = 0; i < 10; i++) begin
      next_cycle(); bus.cw_ready = 1'b0; sample();
      expect_word("stall", 16'd6);
      check("stall_mem_read", 64'(bus.mem_read), 64'd0);
    end
    check("stall_mem_addr", 64'(bus.mem_addr), 64'h8);
    next_cycle(); bus.cw_ready = 1'b1; sample();
    expect_word("release", 16'd6);
    check("release_mem_read", 64'(bus.mem_read), 64'd1);
    check("release_mem_addr", 64'(bus.mem_addr), 64'h8);
    for (int i = 7; i <= 12; i++) begin
      next_cycle(); sample();
      expect_word("resume", AW'(i));
    end

    // Jump to 0x0100 mid-stream: the word popped in the jump cycle survives
    next_cycle(); jump_valid = 1'b1; jump_target = 16'h0100; sample();
    expect_word("jump_pop", 16'd13);
    check("jump_mem_read", 64'(bus.mem_read), 64'd0);
    next_cycle(); jump_valid = 1'b0; sample();
    expect_idle("jump_j1");
    check("jump_j1_mem_read", 64'(bus.mem_read), 64'd1);
    check("jump_j1_mem_addr", 64'(bus.mem_addr), 64'h0100);
    next_cycle(); sample();
    expect_idle("jump_j2");
    next_cycle(); sample();
    expect_word("jump_land", 16'h0100);
    next_cycle(); sample();
    expect_word("jump_next", 16'h0101);

    // Counter wrap through 0xFFFF
    next_cycle(); jump_valid = 1'b1; jump_target = 16'hFFFE; sample();
    expect_word("wrap_pop", 16'h0102);
    next_cycle(); jump_valid = 1'b0; sample();
    expect_idle("wrap_j1");
    next_cycle(); sample();
    expect_idle("wrap_j2");
    wrap_seq[0] = 16'hFFFE; wrap_seq[1] = 16'hFFFF;
    wrap_seq[2] = 16'h0000; wrap_seq[3] = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); sample();
      expect_word("wrap", wrap_seq[i]);
    end

    // Halt for 5 cycles: buffered and in-flight words drain, no new reads
    next_cycle(); halt = 1'b1; sample();
    expect_word("halt_drain", 16'h0002);
    check("halt_h0_mem_read", 64'(bus.mem_read), 64'd0);
    next_cycle(); sample();
    expect_word("halt_inflight", 16'h0003);
    check("halt_h1_mem_read", 64'(bus.mem_read), 64'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); sample();
      expect_idle("halt_empty");
      check("halt_empty_mem_read", 64'(bus.mem_read), 64'd0);
    end
    next_cycle(); halt = 1'b0; sample();
    check("halt_resume_mem_read", 64'(bus.mem_read), 64'd1);
    check("halt_resume_mem_addr", 64'(bus.mem_addr), 64'h0004);
    expect_idle("halt_r0");
    next_cycle(); sample();
    expect_idle("halt_r1");
    next_cycle(); sample();
    expect_word("halt_resume", 16'h0004);

    // Fill the buffer, then reset asynchronously mid-cycle
    next_cycle(); bus.cw_ready = 1'b0; sample();
    expect_word("full_a", 16'h0005);
    check("full_a_mem_read", 64'(bus.mem_read), 64'd0);
    next_cycle(); sample();
    expect_word("full_b", 16'h0005);
    #2; reset_n = 1'b0; #1;
    check("arst_valid",    64'(bus.cw_valid), 64'd0);
    check("arst_mem_read", 64'(bus.mem_read), 64'd0);
    check("arst_mem_addr", 64'(bus.mem_addr), 64'h0);
    next_cycle(); reset_n = 1'b1; bus.cw_ready = 1'b1; sample();
    check("restart_mem_read", 64'(bus.mem_read), 64'd1);
    check("restart_mem_addr", 64'(bus.mem_addr), 64'h0);
    expect_idle("restart_c0");
    next_cycle(); sample();
    expect_idle("restart_c1");
    next_cycle(); sample();
    expect_word("restart_w0", 16'h0000);
    next_cycle(); sample();
    expect_word("restart_w1", 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
`default_nettype wire
